// File: rtl/display_pkg.sv
// Shared constants for the display time-share path: widths, blank mask and
// scheduler state encoding.
package display_pkg;
  localparam int DISP_VALUE_W = 18;
  localparam int DISP_DIGITS  = 4;

  localparam logic [DISP_DIGITS-1:0] BLANK_ALL = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/tick_counter.sv
// Slow-tick counter shared by the hold and gap phases; hit flags the tick that
// completes LIMIT ticks so the owner can act on the same edge.
module tick_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = en && tick && (cnt_q == (limit - CNT_W'(1)));
endmodule

// File: rtl/display_scheduler.sv
// Round-robin time-share of the 7-segment display between two requesters,
// with a tick-measured hold per grant and an optional blank gap between owners.
module display_scheduler
  import display_pkg::*;
#(
  parameter int VALUE_W    = DISP_VALUE_W,
  parameter int HOLD_TICKS = 8,
  parameter int GAP_TICKS  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [1:0]             req,
  input  logic [VALUE_W-1:0]     val0,
  input  logic [VALUE_W-1:0]     val1,
  output logic [1:0]             grant,
  output logic [VALUE_W-1:0]     value,
  output logic [DISP_DIGITS-1:0] anode_d,
  output logic                   done,
  output logic                   busy
);
  localparam int MAX_TICKS = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_TICKS);

  logic [1:0]             state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic                   rr_last_q, rr_last_d;
  logic [VALUE_W-1:0]     value_q, value_d;
  logic [DISP_DIGITS-1:0] blank_q, blank_d;
  logic                   done_q, done_d;

  logic             cnt_en, cnt_clr, cnt_hit;
  logic [CNT_W-1:0] cnt_limit;
  logic             winner, owner;

  // On a tie the requester that did not own the display last time wins.
  assign winner    = (req == 2'b11) ? ~rr_last_q : req[1];
  assign owner     = grant_q[1];
  assign cnt_en    = (state_q == ST_SHOW) || (state_q == ST_GAP);
  assign cnt_limit = (state_q == ST_GAP) ? GAP_LIM : HOLD_LIM;

  tick_counter #(.CNT_W(CNT_W)) u_tick_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .tick  (tick),
    .limit (cnt_limit),
    .hit   (cnt_hit)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    value_d   = value_q;
    blank_d   = blank_q;
    done_d    = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (|req) begin
          grant_d   = onehot2(winner);
          rr_last_d = winner;
          value_d   = winner ? val1 : val0;
          blank_d   = '0;
          state_d   = ST_SHOW;
        end
      end
      ST_SHOW: begin
        value_d = owner ? val1 : val0;
        // Hold expiry and early release share one end path, so one done pulse.
        if (cnt_hit || !req[owner]) begin
          done_d  = 1'b1;
          grant_d = 2'b00;
          value_d = '0;
          blank_d = BLANK_ALL;
          cnt_clr = 1'b1;
          state_d = (GAP_TICKS > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_hit) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        grant_d = 2'b00;
        value_d = '0;
        blank_d = BLANK_ALL;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      rr_last_q <= 1'b1;
      value_q   <= '0;
      blank_q   <= BLANK_ALL;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      value_q   <= value_d;
      blank_q   <= blank_d;
      done_q    <= done_d;
    end
  end

  assign grant   = grant_q;
  assign value   = value_q;
  assign anode_d = blank_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: hold-8/gap-1 instance plus a
// hold-2/gap-0 instance for the back-to-back case.
module tb_display_scheduler;
  localparam int VW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, tick, tick_b;
  logic [1:0]    req, req_b;
  logic [VW-1:0] val0, val1;
  logic [1:0]    grant, grant_b;
  logic [VW-1:0] value, value_b;
  logic [3:0]    anode, anode_b;
  logic          done, done_b, busy, busy_b;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int tick_phase = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_b[$];

  display_scheduler #(.VALUE_W(VW), .HOLD_TICKS(8), .GAP_TICKS(1)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .req(req), .val0(val0), .val1(val1),
    .grant(grant), .value(value), .anode_d(anode), .done(done), .busy(busy)
  );

  display_scheduler #(.VALUE_W(VW), .HOLD_TICKS(2), .GAP_TICKS(0)) dut_b (
    .clk(clk), .rst(rst), .tick(tick_b), .req(req_b), .val0(val0), .val1(val1),
    .grant(grant_b), .value(value_b), .anode_d(anode_b), .done(done_b), .busy(busy_b)
  );

  // Monitor: invariants every cycle, and each new grant popped from the scoreboard.
  initial begin : monitor
    logic [1:0] prev;
    logic [1:0] e;
    prev = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      total++;
      if (!(grant === 2'b00 || grant === 2'b01 || grant === 2'b10) ||
          (grant === 2'b00 && value !== '0)) begin
        bad++;
        $display("FAIL invariant: grant=%b value=%h required one-hot/zero and value 0 when no owner", grant, value);
      end
      if (done === 1'b1) done_cnt++;
      if (prev === 2'b00 && grant !== 2'b00) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_grant: got %b required no grant pending", grant);
        end else begin
          e = exp_q.pop_front();
          if (grant !== e) begin
            bad++;
            $display("FAIL sb_grant: got %b required %b", grant, e);
          end else begin
            $display("grant start %b at %0t", grant, $time);
          end
        end
      end
      prev = grant;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic step(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic step_b(input logic t);
    tick_b = t;
    @(posedge clk);
    #1;
    tick_b = 1'b0;
  endtask

  task automatic tick_clk(output logic ticked);
    ticked = (tick_phase == 3);
    tick_phase = (tick_phase + 1) % 4;
    step(ticked);
  endtask

  task automatic wait_grant_a(input string name);
    int n;
    logic t;
    n = 0;
    while (grant === 2'b00 && n < 40) begin
      tick_clk(t);
      n++;
    end
    total++;
    if (grant === 2'b00) begin
      bad++;
      $display("FAIL %s: got grant=%b after 40 clk, required a grant", name, grant);
    end
  endtask

  task automatic drain_a();
    logic t;
    req = 2'b00;
    repeat (10) tick_clk(t);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy: got %b required 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; req_b = 2'b00; tick = 1'b0; tick_b = 1'b0;
    val0 = '0; val1 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b required 00", grant); end
    total++; if (value !== '0) begin bad++; $display("FAIL reset_value: got %h required 0", value); end
    total++; if (anode !== 4'b1111) begin bad++; $display("FAIL reset_anode: got %b required 1111", anode); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if (anode_b !== 4'b1111) begin bad++; $display("FAIL reset_anode_b: got %b required 1111", anode_b); end
    rst = 1'b0;
    step(1'b1);
    total++; if (busy !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL idle_tick: got busy=%b grant=%b required 0/00", busy, grant); end
    $display("reset checks done");
  endtask

  task automatic test_single();
    val0 = 18'h2A5A5; val1 = 18'h15A5A;
    req = 2'b01;
    exp_q.push_back(2'b01);
    step(1'b0);
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL single_grant: got %b required 01", grant); end
    total++; if (value !== 18'h2A5A5) begin bad++; $display("FAIL single_value: got %h required 2a5a5", value); end
    total++; if (anode !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL single_lit: got anode=%b busy=%b required 0000/1", anode, busy); end
    val0 = 18'h01234;
    step(1'b0);
    total++; if (value !== 18'h01234) begin bad++; $display("FAIL single_follow: got %h required 01234", value); end
    for (int i = 0; i < 7; i++) begin
      step(1'b1); step(1'b0); step(1'b0); step(1'b0);
    end
    total++; if (grant !== 2'b01 || done !== 1'b0) begin bad++; $display("FAIL single_tick7: got grant=%b done=%b required 01/0", grant, done); end
    step(1'b1);
    total++; if (done !== 1'b1 || grant !== 2'b00) begin bad++; $display("FAIL single_end: got done=%b grant=%b required 1/00", done, grant); end
    total++; if (value !== '0 || anode !== 4'b1111 || busy !== 1'b1) begin bad++; $display("FAIL single_gap: got value=%h anode=%b busy=%b required 0/1111/1", value, anode, busy); end
    req = 2'b00;
    step(1'b0);
    total++; if (done !== 1'b0 || anode !== 4'b1111 || busy !== 1'b1) begin bad++; $display("FAIL single_gap_hold: got done=%b anode=%b busy=%b required 0/1111/1", done, anode, busy); end
    step(1'b1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_gap_len: got busy=%b required 0", busy); end
    $display("single requester done");
  endtask

  task automatic test_alternate();
    int d0, n, k;
    logic t;
    d0 = done_cnt;
    tick_phase = 0;
    req = 2'b11;
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    for (int g = 0; g < 4; g++) begin
      wait_grant_a("alt_grant");
      n = 0; k = 0;
      while (grant !== 2'b00 && k < 60) begin
        tick_clk(t);
        if (t) n++;
        k++;
      end
      if (g == 3) req = 2'b00;
      total++; if (n != 8) begin bad++; $display("FAIL alt_hold_ticks: got %0d required 8", n); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL alt_done: got %b required 1", done); end
    end
    drain_a();
    total++; if (done_cnt - d0 != 4) begin bad++; $display("FAIL alt_done_count: got %0d required 4", done_cnt - d0); end
    $display("alternation done");
  endtask

  task automatic test_early_release();
    int n;
    logic t;
    req = 2'b01;
    exp_q.push_back(2'b01);
    wait_grant_a("early_grant");
    req = 2'b11;
    n = 0;
    while (n < 3) begin
      tick_clk(t);
      if (t) n++;
    end
    total++; if (grant !== 2'b01 || done !== 1'b0) begin bad++; $display("FAIL early_nopreempt: got grant=%b done=%b required 01/0", grant, done); end
    req = 2'b10;
    exp_q.push_back(2'b10);
    step(1'b0);
    total++; if (done !== 1'b1 || grant !== 2'b00 || busy !== 1'b1) begin bad++; $display("FAIL early_end: got done=%b grant=%b busy=%b required 1/00/1", done, grant, busy); end
    wait_grant_a("early_next");
    total++; if (grant !== 2'b10 || value !== 18'h15A5A) begin bad++; $display("FAIL early_next: got grant=%b value=%h required 10/15a5a", grant, value); end
    req = 2'b00;
    step(1'b0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL early_drop: got done=%b required 1", done); end
    drain_a();
    $display("early release done");
  endtask

  task automatic test_tick_coincide();
    int d0;
    req = 2'b01;
    exp_q.push_back(2'b01);
    wait_grant_a("coin_grant");
    d0 = done_cnt;
    for (int i = 0; i < 7; i++) begin
      step(1'b1); step(1'b0);
    end
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL coin_hold: got %b required 01", grant); end
    req = 2'b00;
    step(1'b1);
    total++; if (done !== 1'b1 || grant !== 2'b00 || busy !== 1'b1) begin bad++; $display("FAIL coin_end: got done=%b grant=%b busy=%b required 1/00/1", done, grant, busy); end
    step(1'b0);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL coin_single_pulse: got %b required 0", done); end
    step(1'b1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL coin_gap: got busy=%b required 0", busy); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL coin_done_count: got %0d required 1", done_cnt - d0); end
    $display("tick/release coincidence done");
  endtask

  task automatic test_reset_mid_show();
    int d0;
    req = 2'b10;
    exp_q.push_back(2'b10);
    wait_grant_a("rst_grant");
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b1); step(1'b0);
    end
    rst = 1'b1;
    step(1'b0);
    total++; if (grant !== 2'b00 || value !== '0) begin bad++; $display("FAIL rst_mid_out: got grant=%b value=%h required 00/0", grant, value); end
    total++; if (anode !== 4'b1111 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_ctl: got anode=%b done=%b busy=%b required 1111/0/0", anode, done, busy); end
    req = 2'b11;
    step(1'b0);
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL rst_hold: got %b required 00", grant); end
    rst = 1'b0;
    exp_q.push_back(2'b01);
    step(1'b0);
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL rst_rr_winner: got %b required 01", grant); end
    total++; if (done_cnt != d0) begin bad++; $display("FAIL rst_no_done: got %0d pulses required 0", done_cnt - d0); end
    req = 2'b00;
    step(1'b0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rst_after_drop: got done=%b required 1", done); end
    drain_a();
    $display("reset mid-show done");
  endtask

  task automatic test_no_gap();
    int n, k;
    logic [1:0] e;
    req_b = 2'b11;
    exp_b.push_back(2'b01); exp_b.push_back(2'b10); exp_b.push_back(2'b01);
    step_b(1'b1);
    for (int g = 0; g < 3; g++) begin
      e = exp_b.pop_front();
      total++; if (grant_b !== e) begin bad++; $display("FAIL nogap_grant: got %b required %b", grant_b, e); end
      total++; if (anode_b !== 4'b0000) begin bad++; $display("FAIL nogap_lit: got %b required 0000", anode_b); end
      n = 0; k = 0;
      while (grant_b !== 2'b00 && k < 20) begin
        step_b(1'b1);
        n++; k++;
      end
      if (g == 2) req_b = 2'b00;
      total++; if (n != 2) begin bad++; $display("FAIL nogap_hold: got %0d ticks required 2", n); end
      total++; if (done_b !== 1'b1 || busy_b !== 1'b0 || anode_b !== 4'b1111) begin bad++; $display("FAIL nogap_end: got done=%b busy=%b anode=%b required 1/0/1111", done_b, busy_b, anode_b); end
      step_b(1'b1);
      $display("no-gap grant %0d checked", g);
    end
    total++; if (grant_b !== 2'b00 || busy_b !== 1'b0) begin bad++; $display("FAIL nogap_idle: got grant=%b busy=%b required 00/0", grant_b, busy_b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_early_release();
    test_tick_coincide();
    test_reset_mid_show();
    test_no_gap();
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d expected grants unseen required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
